trans_sched: RTL and testbench

//  Control-side initiator for the trans_core crossbar. Accepts transfer requests
//  (one source port, multicast dest mask, word count) and runs up to two concurrent

---
 rtl/trans_pkg.sv | 22 ++
 rtl/trans_sched_lane.sv | 80 ++++++++
 rtl/trans_sched.sv | 84 ++++++++
 tb/tb_trans_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/trans_pkg.sv
// Shared crossbar definitions for the transfer scheduler and the trans_core/trans_lsab benches.
package trans_pkg;

   localparam int unsigned NPORTS = 8;
   localparam int unsigned NLANES = 2;
   localparam int unsigned PIDX_W = 3;

   typedef logic [PIDX_W-1:0] port_idx_t;
   typedef logic [NPORTS-1:0] port_mask_t;

   typedef enum logic [1:0] {
      LANE_IDLE  = 2'd0,
      LANE_RUN   = 2'd1,
      LANE_DRAIN = 2'd2
   } lane_state_e;

   // One-hot select for a single port index
   function automatic port_mask_t port_onehot(input port_idx_t idx);
      port_onehot = port_mask_t'(1) << idx;
   endfunction

endpackage

// File: rtl/trans_sched_lane.sv
// One transfer lane: IDLE/RUN/DRAIN FSM, word counter, captured src/dst, isel slice.
//  CLK, RST     clock, synchronous active-low reset
//  start        accept a request into this lane (only honoured in IDLE)
//  src/dst/len  request fields captured on start
//  idle/run/drain  decoded lane state
//  dst_q        captured destination mask (held through DRAIN)
//  isel         one-hot source select while in RUN
module trans_sched_lane
   import trans_pkg::*;
#(
   parameter int unsigned LEN_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  port_idx_t        src,
   input  port_mask_t       dst,
   input  logic [LEN_W-1:0] len,
   output logic             idle,
   output logic             run,
   output logic             drain,
   output port_mask_t       dst_q,
   output port_mask_t       isel
);

   localparam logic [1:0] ST_IDLE  = LANE_IDLE;
   localparam logic [1:0] ST_RUN   = LANE_RUN;
   localparam logic [1:0] ST_DRAIN = LANE_DRAIN;

   logic [1:0]       state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   port_idx_t        src_q, src_d;
   port_mask_t       dst_d;

   // State and capture registers
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
      end
   end

   // Next state; a zero-length request skips RUN so done still pulses
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      dst_d   = dst_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d = src;
               dst_d = dst;
               cnt_d = len;
               if (len == '0) state_d = ST_DRAIN;
               else           state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign idle  = (state_q == ST_IDLE);
   assign run   = (state_q == ST_RUN);
   assign drain = (state_q == ST_DRAIN);
   assign isel  = run ? port_onehot(src_q) : '0;

endmodule

// File: rtl/trans_sched.sv
// Transfer scheduler for the trans_core crossbar: two lanes, one per fan block.
//  CLK, RST     clock, synchronous active-low reset
//  req_*        request handshake: source index, destination mask, word count
//  isel         [7:0] lane 0 one-hot source, [15:8] lane 1 one-hot source
//  osel         [7:0] output write enables, [15:8] omux (1 = fan_block_0)
//  done         per-lane completion pulse (DRAIN state)
//  busy         per-lane active (RUN or DRAIN)
module trans_sched
   import trans_pkg::*;
#(
   parameter int unsigned LEN_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_src,
   input  logic [7:0]       req_dst,
   input  logic [LEN_W-1:0] req_len,
   output logic [15:0]      isel,
   output logic [15:0]      osel,
   output logic [1:0]       done,
   output logic [1:0]       busy
);

   logic [NLANES-1:0]      lane_idle, lane_run, lane_drain, lane_start;
   port_mask_t [NLANES-1:0] lane_dst, lane_isel;
   port_mask_t             busy_dst;
   port_mask_t             osel_en_d, osel_mux_d;
   logic                   accept;

   // Admission: a free lane, no destination overlap with active lanes, nonzero mask
   always_comb begin
      busy_dst = '0;
      for (int l = 0; l < NLANES; l++) begin
         if (!lane_idle[l]) busy_dst = busy_dst | lane_dst[l];
      end
      req_ready  = (|lane_idle) && ((req_dst & busy_dst) == '0) && (req_dst != '0);
      accept     = req_valid && req_ready;
      lane_start = '0;
      if (accept) begin
         if (lane_idle[0]) lane_start[0] = 1'b1;
         else              lane_start[1] = 1'b1;
      end
   end

   for (genvar g = 0; g < NLANES; g++) begin : g_lane
      trans_sched_lane #(.LEN_W(LEN_W)) u_lane (
         .CLK   (CLK),
         .RST   (RST),
         .start (lane_start[g]),
         .src   (req_src),
         .dst   (req_dst),
         .len   (req_len),
         .idle  (lane_idle[g]),
         .run   (lane_run[g]),
         .drain (lane_drain[g]),
         .dst_q (lane_dst[g]),
         .isel  (lane_isel[g])
      );
   end

   // Output select for the lanes in RUN now; registered so it trails isel by the fan stage
   always_comb begin
      osel_en_d  = '0;
      osel_mux_d = '0;
      for (int l = 0; l < NLANES; l++) begin
         if (lane_run[l]) begin
            osel_en_d = osel_en_d | lane_dst[l];
            if (l == 0) osel_mux_d = osel_mux_d | lane_dst[l];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) osel <= '0;
      else      osel <= {osel_mux_d, osel_en_d};
   end

   assign isel = {lane_isel[1], lane_isel[0]};
   assign done = lane_drain;
   assign busy = ~lane_idle;

endmodule

// File: tb/tb_trans_sched.sv
// Directed bench for trans_sched: inputs change 1 time unit after a rising edge,
// outputs are sampled on the falling edge.
module tb_trans_sched;

   logic        CLK;
   logic        RST;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_src;
   logic [7:0]  req_dst;
   logic [7:0]  req_len;
   logic [15:0] isel;
   logic [15:0] osel;
   logic [1:0]  done;
   logic [1:0]  busy;

   int errors = 0;
   int checks = 0;

   trans_sched #(.LEN_W(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .req_len   (req_len),
      .isel      (isel),
      .osel      (osel),
      .done      (done),
      .busy      (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST       = 1'b0;
      req_valid = 1'b0;
      req_src   = '0;
      req_dst   = '0;
      req_len   = '0;
      next_cycle();
      next_cycle();
      RST = 1'b1;
   endtask

   // Present a request in the current cycle, expect it accepted, return in the next cycle
   task automatic issue(input logic [2:0] src, input logic [7:0] dst, input logic [7:0] len,
                        input string tag);
      req_src   = src;
      req_dst   = dst;
      req_len   = len;
      req_valid = 1'b1;
      @(negedge CLK);
      chk({tag, " accept"}, 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 1'b0;
   endtask

   // Long transfer on lane 0 (src 6, dst 8'h40, len 255): count isel cycles and ready
   task automatic run_long(output int n_isel, output int n_ready, output int done_cyc);
      n_isel   = 0;
      n_ready  = 0;
      done_cyc = 0;
      for (int c = 1; c <= 257; c++) begin
         @(negedge CLK);
         if (isel[6]) n_isel++;
         if (c < 257 && req_ready) n_ready++;
         if (done[0] && done_cyc == 0) done_cyc = c;
         if (c < 257) next_cycle();
      end
   endtask

   initial begin
      logic [15:0] ei, eo;
      logic [1:0]  ed, eb;
      int          n_isel, n_ready, done_cyc;

      // Reset state
      do_reset();
      @(negedge CLK);
      chk("rst isel", 32'(isel), 32'h0);
      chk("rst osel", 32'(osel), 32'h0);
      chk("rst done", 32'(done), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst ready dst0", 32'(req_ready), 32'd0);
      req_dst = 8'h01;
      #1;
      chk("rst ready dst1", 32'(req_ready), 32'd1);
      next_cycle();

      // 1: single transfer src 3, dst 05, len 4
      issue(3'd3, 8'h05, 8'd4, "t1");
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         ei = (c <= 4) ? 16'h0008 : 16'h0000;
         eo = (c >= 2 && c <= 5) ? 16'h0505 : 16'h0000;
         ed = (c == 5) ? 2'b01 : 2'b00;
         eb = (c <= 5) ? 2'b01 : 2'b00;
         chk($sformatf("t1 isel c%0d", c), 32'(isel), 32'(ei));
         chk($sformatf("t1 osel c%0d", c), 32'(osel), 32'(eo));
         chk($sformatf("t1 done c%0d", c), 32'(done), 32'(ed));
         chk($sformatf("t1 busy c%0d", c), 32'(busy), 32'(eb));
         if (c == 6) chk("t1 ready c6", 32'(req_ready), 32'd1);
         next_cycle();
      end

      // 2: lane 0 dst 03 len 10, lane 1 src 7 dst 30 len 3, overlapping dst 06 stalls
      do_reset();
      issue(3'd0, 8'h03, 8'd10, "t2 l0");
      issue(3'd7, 8'h30, 8'd3, "t2 l1");
      req_src = 3'd2;
      req_dst = 8'h06;
      req_len = 8'd1;
      for (int c = 2; c <= 12; c++) begin
         @(negedge CLK);
         ei = ((c <= 10) ? 16'h0001 : 16'h0000) | ((c <= 4) ? 16'h8000 : 16'h0000);
         eo = ((c >= 2 && c <= 11) ? 16'h0303 : 16'h0000) |
              ((c >= 3 && c <= 5) ? 16'h0030 : 16'h0000);
         ed = (c == 5) ? 2'b10 : ((c == 11) ? 2'b01 : 2'b00);
         eb = {1'(c <= 5), 1'(c <= 11)};
         chk($sformatf("t2 isel c%0d", c), 32'(isel), 32'(ei));
         chk($sformatf("t2 osel c%0d", c), 32'(osel), 32'(eo));
         chk($sformatf("t2 done c%0d", c), 32'(done), 32'(ed));
         chk($sformatf("t2 busy c%0d", c), 32'(busy), 32'(eb));
         chk($sformatf("t2 ready c%0d", c), 32'(req_ready), 32'(c == 12));
         next_cycle();
      end

      // 3: two len-2 transfers one cycle apart, third request stalls while both busy
      do_reset();
      issue(3'd1, 8'h01, 8'd2, "t3 l0");
      issue(3'd2, 8'h02, 8'd2, "t3 l1");
      req_src   = 3'd3;
      req_dst   = 8'h04;
      req_len   = 8'd2;
      req_valid = 1'b1;
      for (int c = 2; c <= 5; c++) begin
         if (c == 4) req_valid = 1'b0;
         @(negedge CLK);
         case (c)
            2:       begin ei = 16'h0402; eo = 16'h0101; ed = 2'b00; end
            3:       begin ei = 16'h0400; eo = 16'h0103; ed = 2'b01; end
            4:       begin ei = 16'h0000; eo = 16'h0002; ed = 2'b10; end
            default: begin ei = 16'h0000; eo = 16'h0000; ed = 2'b00; end
         endcase
         chk($sformatf("t3 isel c%0d", c), 32'(isel), 32'(ei));
         chk($sformatf("t3 osel c%0d", c), 32'(osel), 32'(eo));
         chk($sformatf("t3 done c%0d", c), 32'(done), 32'(ed));
         chk($sformatf("t3 ready c%0d", c), 32'(req_ready), 32'(c >= 4));
         if (c == 5) chk("t3 busy c5", 32'(busy), 32'h0);
         next_cycle();
      end

      // 4: zero-length request goes straight to DRAIN
      do_reset();
      issue(3'd1, 8'h80, 8'd0, "t4");
      for (int c = 1; c <= 3; c++) begin
         @(negedge CLK);
         chk($sformatf("t4 isel c%0d", c), 32'(isel), 32'h0);
         chk($sformatf("t4 osel c%0d", c), 32'(osel), 32'h0);
         chk($sformatf("t4 done c%0d", c), 32'(done), 32'(c == 1));
         chk($sformatf("t4 busy c%0d", c), 32'(busy), 32'(c == 1));
         next_cycle();
      end

      // 5: reset during RUN aborts without a done pulse
      do_reset();
      issue(3'd4, 8'h10, 8'd8, "t5");
      next_cycle();
      next_cycle();
      @(negedge CLK);
      chk("t5 isel c3", 32'(isel), 32'h0010);
      chk("t5 osel c3", 32'(osel), 32'h1010);
      RST = 1'b0;
      next_cycle();
      RST = 1'b1;
      @(negedge CLK);
      chk("t5 isel post", 32'(isel), 32'h0);
      chk("t5 osel post", 32'(osel), 32'h0);
      chk("t5 busy post", 32'(busy), 32'h0);
      chk("t5 done post", 32'(done), 32'h0);
      next_cycle();
      issue(3'd5, 8'h20, 8'd1, "t5 new");
      @(negedge CLK);
      chk("t5 new isel", 32'(isel), 32'h0020);
      chk("t5 new busy", 32'(busy), 32'h1);
      next_cycle();

      // 6: two back-to-back len-255 transfers on lane 0
      do_reset();
      issue(3'd6, 8'h40, 8'd255, "t6 a");
      req_valid = 1'b1;
      run_long(n_isel, n_ready, done_cyc);
      chk("t6 a isel cycles", 32'(n_isel), 32'd255);
      chk("t6 a early ready", 32'(n_ready), 32'd0);
      chk("t6 a done cycle", 32'(done_cyc), 32'd256);
      chk("t6 a ready c257", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 1'b0;
      run_long(n_isel, n_ready, done_cyc);
      chk("t6 b isel cycles", 32'(n_isel), 32'd255);
      chk("t6 b early ready", 32'(n_ready), 32'd0);
      chk("t6 b done cycle", 32'(done_cyc), 32'd256);
      chk("t6 b busy c257", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
